matrix_scan_sched: RTL
======================

// Module: matrix_scan_sched
// PURPOSE
//  Time-multiplexed scan scheduler for the 8x8 RGB LED matrix and the 4-digit 7-seg display.
//  Arbitrates N_SRC frame sources (e.g. game field, idle heart, miss emoji, fail scroll).
//  Generates row/digit scan timing and muxes the winning source onto the display pins.
//  Grant changes only on frame boundaries, so frames never tear.
// PARAMETERS
//  CLK_HZ   50_000_000  input clock frequency
//  SCAN_HZ  10_000      row/digit step rate; DIV = CLK_HZ/SCAN_HZ (must be >=2)
//  N_SRC    4           number of frame sources (1..8); higher index = higher priority
// PORTS
//  CLK          in   1          system clock, all logic on posedge
//  RST_N        in   1          reset, asynchronous, active-low
//  SRC_REQ      in   N_SRC      level request per source
//  SRC_R        in   8*N_SRC    row pixels, red, active-low; source i at [8i+7:8i], for ROW_IDX
//  SRC_G        in   8*N_SRC    as SRC_R, green
//  SRC_B        in   8*N_SRC    as SRC_R, blue
//  SRC_SEG      in   28*N_SRC   4 digits x 7 seg, active-low; digit d of src i at [28i+7d+6:28i+7d]
//  SRC_GNT      out  N_SRC      one-hot grant, all-zero when idle
//  ROW_IDX      out  3          row being fetched from sources (registered)
//  FRAME_START  out  1          1-cycle pulse when ROW_IDX wraps 7->0
//  DATA_R       out  8          matrix red, active-low
//  DATA_G       out  8          matrix green, active-low
//  DATA_B       out  8          matrix blue, active-low
//  COMM         out  4          {enable, row[2:0]} to matrix decoder
//  COM          out  4          7-seg digit select, active-low one-hot
//  SEG          out  7          7-seg segments, active-low
// BEHAVIOUR
//  Reset values (asynchronous on RST_N=0, also mid-frame):
//   - div=0; ROW_IDX=0; dig=0; SRC_GNT=0; FRAME_START=0
//   - DATA_R/G/B=8'hFF; COMM=4'b0000; COM=4'b1111; SEG=7'b1111111
//  Divider: counts 0..DIV-1, then wraps. tick=1 for one cycle when div==DIV-1.
//  Tick cycle T:
//   - ROW_IDX<=ROW_IDX+1 (mod 8); dig<=dig+1 (mod 4)
//   - DATA_R/G/B<=8'hFF for exactly one cycle (ghost blanking); COMM/COM/SEG hold
//   - If ROW_IDX==7:
//     - FRAME_START<=1
//     - SRC_GNT<=one-hot of the highest-index asserted SRC_REQ, or 0 if none
//  Cycle T+1 (update; sources respond combinationally to ROW_IDX/SRC_GNT valid since T):
//   - Granted source g:
//     - DATA_x<=SRC_x[g][ROW_IDX]; COMM<={1,ROW_IDX}
//     - COM<=~(4'b0001<<dig); SEG<=SRC_SEG[g][dig]
//   - No grant: DATA_x=8'hFF, COMM=4'b0000, COM=4'b1111, SEG=7'b1111111
//   - Granted source whose SRC_REQ has dropped: treated as no grant until the frame boundary,
//     where the grant is re-arbitrated
//  Outputs hold between update cycles. Row-to-pixel latency is 1 cycle after ROW_IDX changes.
//  Simultaneous events:
//   - Request rising mid-frame waits for the boundary, even if it outranks the current owner
//   - Multiple requests: highest index wins; no starvation protection (priority by design)
//   - REQ changes in the same cycle as the boundary tick are sampled that cycle
//  Row and digit counters free-run regardless of grant (scan never stalls).
//  Widths: div is $clog2(DIV) bits; all indices are unsigned; no arithmetic overflow paths.
// TESTING (CLK_HZ=16, SCAN_HZ=4 -> DIV=4, N_SRC=4)
//  1 RST_N=0 then 1, no REQ, 40 cycles
//    -> tick every 4th cycle; ROW_IDX 0..7 wraps
//    -> FRAME_START every 32 cycles; all outputs at blank values, GNT=0
//  2 REQ=4'b0001, src0 row r = 8'hF0|r, digits 7'h01
//    -> GNT=0001 at first boundary
//    -> next frame: DATA_R cycles F0..F7; COMM=1rrr; COM walks 1110,1101,1011,0111; SEG=7'h01
//  3 REQ=0001, then REQ[3]=1 at ROW_IDX=3
//    -> src0 shown through row 7
//    -> GNT=1000 at the 7->0 tick; row 0 shows src3 data
//  4 Granted REQ[0] drops at ROW_IDX=2
//    -> next update cycle onward: blank outputs
//    -> GNT stays 0001 until the boundary, then 0000
//  5 Check the cycle after every tick
//    -> DATA_R/G/B==8'hFF for exactly one cycle, then source data
//  6 Assert RST_N=0 at ROW_IDX=5 mid-frame
//    -> same cycle: all outputs at reset values
//    -> after release: divider restarts at 0; first tick 4 cycles later, ROW_IDX=1

Source files
------------

// File: rtl/matrix_scan_sched.sv
// matrix_scan_sched: frame-boundary arbitration and row/digit scan mux for the 8x8 RGB matrix and 4-digit 7-seg display
module matrix_scan_sched #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int SCAN_HZ = 10_000,
  parameter int N_SRC   = 4
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [N_SRC-1:0]    SRC_REQ,
  input  logic [8*N_SRC-1:0]  SRC_R,
  input  logic [8*N_SRC-1:0]  SRC_G,
  input  logic [8*N_SRC-1:0]  SRC_B,
  input  logic [28*N_SRC-1:0] SRC_SEG,
  output logic [N_SRC-1:0]    SRC_GNT,
  output logic [2:0]          ROW_IDX,
  output logic                FRAME_START,
  output logic [7:0]          DATA_R,
  output logic [7:0]          DATA_G,
  output logic [7:0]          DATA_B,
  output logic [3:0]          COMM,
  output logic [3:0]          COM,
  output logic [6:0]          SEG
);
  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int DW = DIV > 2 ? $clog2(DIV) : 1;
  localparam logic [N_SRC-1:0] ONE = 1;
  logic [DW-1:0] div;
  logic [1:0] dig;
  logic upd, tick, own;
  logic [N_SRC-1:0] win;
  logic [7:0] r_sel, g_sel, b_sel;
  logic [6:0] seg_sel;
  assign tick = div == DW'(DIV - 1);
  // a granted source that has dropped its request is shown as blank until re-arbitrated
  always_comb begin
    win = '0;
    own = 1'b0;
    r_sel = '1;
    g_sel = '1;
    b_sel = '1;
    seg_sel = '1;
    for (int i = 0; i < N_SRC; i++) begin
      if (SRC_REQ[i]) win = ONE << i;
      if (SRC_GNT[i]) begin
        own = SRC_REQ[i];
        r_sel = SRC_R[8*i +: 8];
        g_sel = SRC_G[8*i +: 8];
        b_sel = SRC_B[8*i +: 8];
        seg_sel = SRC_SEG[28*i + 7*dig +: 7];
      end
    end
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div <= '0;
      dig <= '0;
      upd <= 1'b0;
      ROW_IDX <= '0;
      SRC_GNT <= '0;
      FRAME_START <= 1'b0;
      DATA_R <= '1;
      DATA_G <= '1;
      DATA_B <= '1;
      COMM <= '0;
      COM <= '1;
      SEG <= '1;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      upd <= tick;
      FRAME_START <= tick && ROW_IDX == 3'd7;
      if (tick) begin
        ROW_IDX <= ROW_IDX + 1'b1;
        dig <= dig + 1'b1;
        DATA_R <= '1;
        DATA_G <= '1;
        DATA_B <= '1;
        if (ROW_IDX == 3'd7) SRC_GNT <= win;
      end else if (upd) begin
        DATA_R <= own ? r_sel : '1;
        DATA_G <= own ? g_sel : '1;
        DATA_B <= own ? b_sel : '1;
        COMM <= own ? {1'b1, ROW_IDX} : 4'b0000;
        COM <= own ? ~(4'b0001 << dig) : 4'b1111;
        SEG <= own ? seg_sel : '1;
      end
    end
  end
endmodule
